aoi_vector_sequencer: RTL and testbench

Self-test sequencer for the AND-OR gate cell (out = c | (a & b)). On a start pulse it drives all 8 input combinations onto the cell and waits a programmable settle time covering the cell's specified path delays. It then samples the cell output, compares it against the golden function, and reports an error count, first failing vector and pass/fail. It sits between the board control logic and the gate-level cell instance, and it is the only driver of the cell's inputs.

---
 rtl/aoi_pkg.sv | 20 ++
 rtl/aoi_settle_timer.sv | 43 ++++
 rtl/aoi_vector_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_aoi_vector_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// Shared types and helpers for the AND-OR cell self-test sequencer.
// The golden function lives here so the sequencer and any scoreboard agree on it.
package aoi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } aoi_state_e;

    localparam int         VEC_N    = 8;
    localparam logic [2:0] VEC_LAST = 3'(VEC_N - 1);

    // Golden behaviour of the cell under test: out = c | (a & b).
    function automatic logic aoi_expected(input logic a, input logic b, input logic c);
        return c | (a & b);
    endfunction

endpackage

// File: rtl/aoi_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// Loading places SETTLE_CYC-1 in the counter; zero_o flags the final settle cycle.
module aoi_settle_timer #(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int           CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over decrement; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aoi_vector_sequencer.sv
// Self-test sequencer for the AND-OR cell: walks all 8 input vectors LOOPS times,
// holds each for SETTLE_CYC cycles plus one sample cycle, and scores the cell output.
// Every output is taken straight from a register so the cell sees glitch-free inputs.
module aoi_vector_sequencer
    import aoi_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int LOOPS      = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             dut_out_i,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [2:0]       vec_idx_o,
    output logic             fail_valid_o,
    output logic [2:0]       fail_vec_o
);

    if ((SETTLE_CYC < 1) || (SETTLE_CYC > 255)) begin : g_bad_settle
        $error("aoi_vector_sequencer: SETTLE_CYC must be within 1..255");
    end
    if ((LOOPS < 1) || (LOOPS > 15)) begin : g_bad_loops
        $error("aoi_vector_sequencer: LOOPS must be within 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("aoi_vector_sequencer: CNT_W must be at least 1");
    end

    localparam logic [3:0]       LOOP_LAST = 4'(LOOPS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ERR_ONE   = CNT_W'(1);

    aoi_state_e       state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       loop_q, loop_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [2:0]       fvec_q, fvec_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [2:0]       abc_q, abc_d;

    logic tmr_load_s;
    logic tmr_dec_s;
    logic tmr_zero_s;
    logic expected_s;
    logic mismatch_s;

    aoi_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load_s),
        .dec_i  (tmr_dec_s),
        .zero_o (tmr_zero_s)
    );

    // The vector register is what the cell is currently seeing, so score against it.
    assign expected_s = aoi_expected(vec_q[2], vec_q[1], vec_q[0]);
    assign mismatch_s = (dut_out_i != expected_s);

    // Next-state, scoring and output-register decode; abort overrides everything while busy.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        loop_d     = loop_q;
        err_d      = err_q;
        fv_d       = fv_q;
        fvec_d     = fvec_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        abc_d      = abc_q;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    err_d      = '0;
                    fv_d       = 1'b0;
                    fvec_d     = 3'd0;
                    pass_d     = 1'b0;
                    vec_d      = 3'd0;
                    loop_d     = 4'd0;
                    tmr_load_s = 1'b1;
                    abc_d      = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    busy_d  = 1'b0;
                    abc_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    abc_d   = 3'd0;
                    vec_d   = 3'd0;
                end else if (tmr_zero_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    abc_d   = 3'd0;
                    vec_d   = 3'd0;
                end else begin
                    if (mismatch_s) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_ONE;
                        end else begin
                            err_d = err_q;
                        end
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fvec_d = vec_q;
                        end else begin
                            fv_d = fv_q;
                        end
                    end else begin
                        err_d = err_q;
                    end

                    if ((vec_q == VEC_LAST) && (loop_q == LOOP_LAST)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        abc_d   = 3'd0;
                        vec_d   = 3'd0;
                    end else begin
                        vec_d = vec_q + 3'd1;
                        if (vec_q == VEC_LAST) begin
                            loop_d = loop_q + 4'd1;
                        end else begin
                            loop_d = loop_q;
                        end
                        tmr_load_s = 1'b1;
                        abc_d      = vec_d;
                        state_d    = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                abc_d   = 3'd0;
                vec_d   = 3'd0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                abc_d   = 3'd0;
                vec_d   = 3'd0;
            end
        endcase
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            loop_q  <= 4'd0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= 3'd0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            abc_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            loop_q  <= loop_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            abc_q   <= abc_d;
        end
    end

    assign a_o          = abc_q[2];
    assign b_o          = abc_q[1];
    assign c_o          = abc_q[0];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_cnt_o    = err_q;
    assign vec_idx_o    = vec_q;
    assign fail_valid_o = fv_q;
    assign fail_vec_o   = fvec_q;

endmodule

// File: tb/tb_aoi_vector_sequencer.sv
// Bench for aoi_vector_sequencer: three instances with different parameter sets,
// each driving its own behavioural cell (delay line plus fault injection).
module tb_aoi_vector_sequencer;
    import aoi_pkg::*;

    localparam int S_P [3] = '{4, 2, 8};
    localparam int L_P [3] = '{1, 3, 3};
    localparam int W_P [3] = '{8, 8, 3};

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    logic [2:0] a_v, b_v, c_v, busy_v, done_v, pass_v, fv_v;
    logic [7:0] err_v  [3];
    logic [2:0] vec_v  [3];
    logic [2:0] fvec_v [3];

    // Cell fault model: 0 = golden function XOR mask, 1 = stuck-at-0, 2 = stuck-at-1.
    int         mode_v [3];
    int         dly_v  [3];
    logic [7:0] mask_v [3];

    int n_checks;
    int n_errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = W_P[g];
        logic         a_w, b_w, c_w, busy_w, done_w, pass_w, fv_w;
        logic [W-1:0] err_w;
        logic [2:0]   vec_w, fvec_w;
        logic         cell_out;
        logic [2:0]   abc_now;
        logic [2:0]   abc_seen;
        logic [2:0]   hist [16];

        aoi_vector_sequencer #(
            .SETTLE_CYC (S_P[g]),
            .LOOPS      (L_P[g]),
            .CNT_W      (W)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start_i      (start_v[g]),
            .abort_i      (abort_v[g]),
            .dut_out_i    (cell_out),
            .a_o          (a_w),
            .b_o          (b_w),
            .c_o          (c_w),
            .busy_o       (busy_w),
            .done_o       (done_w),
            .pass_o       (pass_w),
            .err_cnt_o    (err_w),
            .vec_idx_o    (vec_w),
            .fail_valid_o (fv_w),
            .fail_vec_o   (fvec_w)
        );

        assign abc_now   = {a_w, b_w, c_w};
        assign a_v[g]    = a_w;
        assign b_v[g]    = b_w;
        assign c_v[g]    = c_w;
        assign busy_v[g] = busy_w;
        assign done_v[g] = done_w;
        assign pass_v[g] = pass_w;
        assign fv_v[g]   = fv_w;
        assign err_v[g]  = 8'(err_w);
        assign vec_v[g]  = vec_w;
        assign fvec_v[g] = fvec_w;

        // Input history of the cell: hist[i] is the vector applied i+1 cycles ago.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) hist[i] <= 3'd0;
            end else begin
                for (int i = 15; i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= abc_now;
            end
        end

        // Cell output responds to the input applied dly_v cycles earlier.
        always_comb begin
            abc_seen = (dly_v[g] == 0) ? abc_now : hist[dly_v[g] - 1];
            case (mode_v[g])
                1:       cell_out = 1'b0;
                2:       cell_out = 1'b1;
                default: cell_out = aoi_expected(abc_seen[2], abc_seen[1], abc_seen[0])
                                    ^ mask_v[g][abc_seen];
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs(input int g);
        return {12'd0, a_v[g], b_v[g], c_v[g], busy_v[g], done_v[g], pass_v[g],
                fv_v[g], fvec_v[g], vec_v[g], err_v[g]};
    endfunction

    // Scoreboard: walk the vector list LOOPS times and score the modelled cell.
    task automatic ref_run(input int g, output int e, output bit fv, output int fvec);
        int         sat;
        logic [2:0] x;
        bit         good;
        bit         seen;
        sat  = (1 << W_P[g]) - 1;
        e    = 0;
        fv   = 1'b0;
        fvec = 0;
        for (int l = 0; l < L_P[g]; l++) begin
            for (int v = 0; v < VEC_N; v++) begin
                x    = 3'(v);
                good = aoi_expected(x[2], x[1], x[0]);
                if (mode_v[g] == 1)      seen = 1'b0;
                else if (mode_v[g] == 2) seen = 1'b1;
                else                     seen = good ^ mask_v[g][v];
                if (seen != good) begin
                    if (e < sat) e++;
                    if (!fv) begin
                        fv   = 1'b1;
                        fvec = v;
                    end
                end
            end
        end
    endtask

    // Start a run on instance g; optionally check every driven vector and
    // re-pulse start_i at cycle extra_at (which must be ignored).
    task automatic run(input int g, input bit chk_vec, input int extra_at);
        int j_exp;
        int j;
        int got;
        int exp_vec;
        j_exp = 1 + VEC_N * L_P[g] * (S_P[g] + 1);
        got   = -1;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        j = 1;
        while (j <= j_exp + 20) begin
            start_v[g] = (j == extra_at);
            if (chk_vec && (j <= j_exp)) begin
                exp_vec = (j < j_exp) ? (((j - 1) / (S_P[g] + 1)) % VEC_N) : 0;
                chk_eq("abc", {29'd0, a_v[g], b_v[g], c_v[g]}, exp_vec);
                chk_eq("busy_run", busy_v[g], 1);
            end
            if (done_v[g]) begin
                got = j;
                break;
            end
            @(negedge clk);
            j++;
        end
        start_v[g] = 1'b0;
        chk_eq("done_cycle", got, j_exp);
        @(negedge clk);
        chk_eq("done_width", done_v[g], 0);
        chk_eq("busy_after", busy_v[g], 0);
    endtask

    task automatic check_result(input int g, input int e, input bit fv, input int fvec);
        chk_eq("err_cnt", err_v[g], e);
        chk_eq("fail_valid", fv_v[g], fv);
        if (fv) chk_eq("fail_vec", fvec_v[g], fvec);
        chk_eq("pass", pass_v[g], (e == 0));
    endtask

    task automatic set_cell(input int g, input int mode, input int dly, input logic [7:0] mask);
        mode_v[g] = mode;
        dly_v[g]  = dly;
        mask_v[g] = mask;
    endtask

    initial begin
        int e;
        bit fv;
        int fvec;
        int g;
        int r;
        int dones;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start_v  = 3'd0;
        abort_v  = 3'd0;
        for (int i = 0; i < 3; i++) set_cell(i, 0, 0, 8'h00);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_eq("reset_outs", all_outs(i), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good cell with 3-cycle delay: vector timing, done cycle and clean result.
        set_cell(0, 0, 3, 8'h00);
        run(0, 1'b1, 0);
        check_result(0, 0, 1'b0, 0);

        // Stuck-at-0: vectors 1,3,5,6,7 fail.
        set_cell(0, 1, 0, 8'h00);
        run(0, 1'b0, 0);
        check_result(0, 5, 1'b1, 1);

        // Stuck-at-1 over three loops: vectors 0,2,4 fail each loop.
        set_cell(1, 2, 0, 8'h00);
        run(1, 1'b1, 0);
        check_result(1, 9, 1'b1, 0);

        // Stuck-at-0 over three loops with a 3-bit counter saturates at 7.
        set_cell(2, 1, 0, 8'h00);
        run(2, 1'b0, 0);
        check_result(2, 7, 1'b1, 1);

        // Cell slower than the settle time fails; ample settle time passes.
        set_cell(1, 0, 6, 8'h00);
        run(1, 1'b0, 0);
        chk_eq("slow_err_nz", (err_v[1] != 8'd0), 1);
        chk_eq("slow_pass", pass_v[1], 0);
        set_cell(2, 0, 6, 8'h00);
        run(2, 1'b0, 0);
        check_result(2, 0, 1'b0, 0);

        // Abort 12 cycles into a stuck-at-0 run (vector 1 already scored).
        set_cell(0, 1, 0, 8'h00);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (11) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk_eq("abort_busy", busy_v[0], 0);
        chk_eq("abort_abc", {a_v[0], b_v[0], c_v[0]}, 0);
        chk_eq("abort_err_hold", err_v[0], 1);
        chk_eq("abort_fvec_hold", fvec_v[0], 1);
        chk_eq("abort_pass", pass_v[0], 0);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (done_v[0]) dones++;
            @(negedge clk);
        end
        chk_eq("abort_no_done", dones, 0);
        set_cell(0, 0, 3, 8'h00);
        run(0, 1'b1, 0);
        check_result(0, 0, 1'b0, 0);

        // start_i while busy must not restart or extend the run.
        set_cell(0, 1, 0, 8'h00);
        run(0, 1'b1, 7);
        check_result(0, 5, 1'b1, 1);

        // start_i with abort_i in IDLE is ignored.
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk_eq("start_abort_idle", busy_v[0], 0);
        @(negedge clk);
        chk_eq("start_abort_idle2", busy_v[0], 0);

        // Asynchronous reset in the middle of SETTLE (vector 1, one error recorded).
        set_cell(0, 2, 0, 8'h00);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk_eq("pre_reset_busy", busy_v[0], 1);
        #2 rst_n = 1'b0;
        #1 chk_eq("async_reset_outs", all_outs(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized faults and delays within the settle budget against the scoreboard.
        for (int it = 0; it < 10; it++) begin
            g = $urandom_range(0, 2);
            r = $urandom_range(0, 3);
            if (r <= 1) set_cell(g, 0, $urandom_range(0, S_P[g]), (r == 0) ? 8'h00 : 8'($urandom));
            else        set_cell(g, r - 1, 0, 8'h00);
            run(g, 1'b1, 0);
            ref_run(g, e, fv, fvec);
            check_result(g, e, fv, fvec);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound in case a run never ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
